// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} fetch_state_t;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [31:0] PC_STEP_DEF = 32'd4;
endpackage

// File: rtl/adder_32.sv
// adder_32: modulo-2^WIDTH adder used as the PC incrementer
module adder_32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);
   assign sum_o = a_i + b_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one imem request at a time, presents instructions to decode
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(PC_STEP_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_pc_plus4,
   output logic [31:0]      out_instr
);
   fetch_state_t     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, pc_inc, req_pc_inc;
   logic [WIDTH-1:0] out_pc_q, out_pc_d, out_pc_plus4_q, out_pc_plus4_d;
   logic [31:0]      out_instr_q, out_instr_d;
   logic             out_valid_q, out_valid_d, req_hs;

   adder_32 #(.WIDTH(WIDTH)) u_pc_inc  (.a_i(pc_q),     .b_i(PC_STEP), .sum_o(pc_inc));
   adder_32 #(.WIDTH(WIDTH)) u_req_inc (.a_i(req_pc_q), .b_i(PC_STEP), .sum_o(req_pc_inc));

   assign imem_req_valid = (state_q == S_REQ) && (!out_valid_q || out_ready);
   assign imem_addr      = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign out_valid      = out_valid_q;
   assign out_pc         = out_pc_q;
   assign out_pc_plus4   = out_pc_plus4_q;
   assign out_instr      = out_instr_q;

   // Next-state logic; a redirect overrides everything else and kills the output slot
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      req_pc_d       = req_pc_q;
      out_valid_d    = out_valid_q && !out_ready;
      out_pc_d       = out_pc_q;
      out_pc_plus4_d = out_pc_plus4_q;
      out_instr_d    = out_instr_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: if (req_hs) begin
            state_d  = S_WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_inc;
         end
         S_WAIT: if (imem_rsp_valid && !redirect_valid) begin
            state_d        = S_REQ;
            out_valid_d    = 1'b1;
            out_pc_d       = req_pc_q;
            out_pc_plus4_d = req_pc_inc;
            out_instr_d    = imem_rsp_data;
         end
         S_DROP: if (imem_rsp_valid) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
      if (redirect_valid) begin
         pc_d        = redirect_pc & ~WIDTH'(3);
         out_valid_d = 1'b0;
         // A response landing with the redirect is the one being killed, so no drop is owed for it
         state_d     = (req_hs || ((state_q == S_WAIT || state_q == S_DROP) && !imem_rsp_valid))
                       ? S_DROP : S_REQ;
      end
   end

   // State, PC and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         pc_q           <= RESET_PC;
         req_pc_q       <= '0;
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_pc_plus4_q <= '0;
         out_instr_q    <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         req_pc_q       <= req_pc_d;
         out_valid_q    <= out_valid_d;
         out_pc_q       <= out_pc_d;
         out_pc_plus4_q <= out_pc_plus4_d;
         out_instr_q    <= out_instr_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;
   logic        clk = 0, rst_n = 0;
   logic        req_valid, req_ready = 1, rsp_valid, redirect_valid = 0, out_valid, out_ready = 1;
   logic [31:0] addr, rsp_data, redirect_pc = 0, out_pc, out_pc_plus4, out_instr;
   logic        req_valid2, rsp_valid2, out_valid2;
   logic [31:0] addr2, rsp_data2, out_pc2, out_pc_plus42, out_instr2;
   logic [3:0]  lat = 1, cnt, cnt2;
   logic [31:0] mad, mad2;
   logic        seen_drop = 0;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   fetch_stage u_dut (
      .clk(clk), .rst_n(rst_n), .imem_req_valid(req_valid), .imem_req_ready(req_ready),
      .imem_addr(addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req_valid(req_valid2), .imem_req_ready(1'b1),
      .imem_addr(addr2), .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(out_valid2),
      .out_ready(1'b1), .out_pc(out_pc2), .out_pc_plus4(out_pc_plus42), .out_instr(out_instr2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hAAAA, a[17:2] + 16'd1};
   endfunction

   // Memory answers exactly once, lat cycles after each accepted request
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 0; mad <= 0; cnt2 <= 0; mad2 <= 0;
      end else begin
         if (req_valid && req_ready) begin cnt <= lat; mad <= addr; end
         else if (cnt != 0) cnt <= cnt - 1;
         if (req_valid2) begin cnt2 <= 1; mad2 <= addr2; end
         else if (cnt2 != 0) cnt2 <= cnt2 - 1;
      end
   end
   assign rsp_valid  = (cnt == 1);
   assign rsp_data   = mem_word(mad);
   assign rsp_valid2 = (cnt2 == 1);
   assign rsp_data2  = mem_word(mad2);

   always @(negedge clk)
      if (out_valid && (out_instr == 32'hAAAA0003 || out_instr == 32'hAAAA0042)) seen_drop = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp_addr);
      for (int i = 0; i < 30 && !req_valid; i++) @(negedge clk);
      chk({tag, "_req_seen"}, 32'(req_valid), 1);
      chk({tag, "_addr"}, addr, exp_addr);
   endtask

   task automatic wait_out(input string tag, input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins);
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_pc4"}, out_pc_plus4, pc4);
      chk({tag, "_instr"}, out_instr, ins);
   endtask

   initial begin
      step(2);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_addr", addr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      rst_n = 1;
      step(1);
      chk("first_req_valid", 32'(req_valid), 1);
      chk("first_addr", addr, 0);
      step(1);
      chk("wait_no_req", 32'(req_valid), 0);
      chk("wait_no_out", 32'(out_valid), 0);
      step(1);
      chk("i0_valid", 32'(out_valid), 1);
      chk("i0_pc", out_pc, 0);
      chk("i0_pc4", out_pc_plus4, 4);
      chk("i0_instr", out_instr, 32'hAAAA0001);
      chk("second_addr", addr, 4);
      step(1);
      chk("i0_consumed", 32'(out_valid), 0);
      step(1);
      chk("i1_valid", 32'(out_valid), 1);
      chk("i1_pc", out_pc, 4);
      chk("i1_pc4", out_pc_plus4, 8);
      chk("i1_instr", out_instr, 32'hAAAA0002);
      out_ready = 0;
      #1 chk("stall_req_valid", 32'(req_valid), 0);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_pc", out_pc, 4);
         chk("stall_instr", out_instr, 32'hAAAA0002);
         chk("stall_no_req", 32'(req_valid), 0);
      end
      lat = 3;
      out_ready = 1;
      #1 chk("unstall_req", 32'(req_valid), 1);
      chk("unstall_addr", addr, 8);
      step(1);
      redirect_valid = 1; redirect_pc = 32'h100;
      step(1);
      redirect_valid = 0;
      chk("drop_no_req", 32'(req_valid), 0);
      chk("drop_no_out", 32'(out_valid), 0);
      lat = 1;
      wait_req("redir100", 32'h100);
      wait_out("o100", 32'h100, 32'h104, 32'hAAAA0041);
      lat = 2;
      redirect_valid = 1; redirect_pc = 32'h203;
      #1 chk("hs_redir_req", 32'(req_valid), 1);
      chk("hs_redir_addr", addr, 32'h104);
      step(1);
      redirect_valid = 0;
      chk("hs_drop_no_req", 32'(req_valid), 0);
      chk("hs_drop_no_out", 32'(out_valid), 0);
      wait_req("redir200", 32'h200);
      wait_out("o200", 32'h200, 32'h204, 32'hAAAA0081);
      req_ready = 0;
      step(1);
      chk("hold_req", 32'(req_valid), 1);
      chk("hold_addr", addr, 32'h204);
      redirect_valid = 1; redirect_pc = 32'h300;
      step(1);
      redirect_valid = 0;
      chk("noshake_redir_req", 32'(req_valid), 1);
      chk("noshake_redir_addr", addr, 32'h300);
      req_ready = 1;
      wait_out("o300", 32'h300, 32'h304, 32'hAAAA00C1);
      chk("dropped_never_shown", 32'(seen_drop), 0);
      lat = 4;
      step(1);
      chk("pre_reset_in_wait", 32'(req_valid), 0);
      rst_n = 0;
      #1 chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_req", 32'(req_valid), 0);
      chk("mid_rst_addr", addr, 0);
      chk("mid_rst_instr", out_instr, 0);
      lat = 1;
      step(2);
      rst_n = 1;
      wait_req("restart", 32'h0);
      wait_out("restart_o", 32'h0, 32'h4, 32'hAAAA0001);
      chk("wrap_valid", 32'(out_valid2), 1);
      chk("wrap_pc", out_pc2, 32'hFFFF_FFFC);
      chk("wrap_pc4", out_pc_plus42, 32'h0);
      chk("wrap_instr", out_instr2, 32'hAAAA0000);
      chk("wrap_next_req", 32'(req_valid2), 1);
      chk("wrap_next_addr", addr2, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
